// File: rtl/debug_slave_pkg.sv
// Shared types and default widths for the CPU debug slave command dispatcher.
package debug_slave_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } dispatch_state_t;

  localparam int DBG_DATA_W = 38;
  localparam int DBG_IR_W   = 2;

endpackage

// File: rtl/debug_slave_cmd_fifo.sv
// Small synchronous command queue. A push into a full queue is still
// accepted when a pop happens on the same edge.
module debug_slave_cmd_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage array; contents need no reset, the count qualifies them.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/debug_slave_cmd_dispatch.sv
// Debug data-register update dispatcher: queues {ir, data} updates and issues
// each as a held jdo word plus one single-cycle action / no-action pulse on
// the IR-selected channel, waiting for that channel's ready with a timeout.
// Handshake: a command is consumed from the queue only in IDLE; in ISSUE the
// pulse fires on the first cycle ch_ready[cur_ch] is high, otherwise the
// command is dropped after TIMEOUT cycles (TIMEOUT = 0 waits forever).
module debug_slave_cmd_dispatch
  import debug_slave_pkg::*;
#(
  parameter int DATA_W     = DBG_DATA_W,
  parameter int IR_W       = DBG_IR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          upd_valid,
  input  logic [IR_W-1:0]               upd_ir,
  input  logic [DATA_W-1:0]             upd_data,
  input  logic [(2**IR_W)-1:0]          ch_ready,
  input  logic                          clear_err,
  output logic [DATA_W-1:0]             jdo,
  output logic [(2**IR_W)-1:0]          take_action,
  output logic [(2**IR_W)-1:0]          take_no_action,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow_err,
  output logic                          timeout_err,
  output dispatch_state_t               dbg_state
);

  localparam int NCH = 2**IR_W;
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  dispatch_state_t          r_state;
  dispatch_state_t          w_next_state;
  logic [TW-1:0]            r_timer;
  logic [DATA_W-1:0]        r_jdo;
  logic [IR_W-1:0]          r_cur_ch;
  logic                     r_act_flag;
  logic [NCH-1:0]           r_take_action;
  logic [NCH-1:0]           r_take_no_action;
  logic                     r_overflow_err;
  logic                     r_timeout_err;

  logic [IR_W+DATA_W-1:0]   w_head;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                     w_pop;
  logic                     w_fire;
  logic                     w_drop;
  logic                     w_ready;
  logic                     w_overflow;
  logic [NCH-1:0]           w_onehot;

  debug_slave_cmd_fifo #(
    .WIDTH (IR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (upd_valid),
    .pop   (w_pop),
    .din   ({upd_ir, upd_data}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_ready    = ch_ready[r_cur_ch];
  assign w_onehot   = {{(NCH-1){1'b0}}, 1'b1} << r_cur_ch;
  assign w_overflow = upd_valid && w_full && !w_pop;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state: fetch when work is queued, return once issued or dropped.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_empty)          w_next_state = ISSUE;
      ISSUE:   if (w_fire || w_drop)  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: pop strobe, issue strobe and timeout-drop strobe.
  always_comb begin
    w_pop  = 1'b0;
    w_fire = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      IDLE: w_pop = !w_empty;
      ISSUE: begin
        if (w_ready)                            w_fire = 1'b1;
        else if (TIMEOUT != 0 && r_timer == TLAST) w_drop = 1'b1;
      end
      default: ;
    endcase
  end

  // Command latch, wait timer and single-cycle pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_jdo            <= '0;
      r_cur_ch         <= '0;
      r_act_flag       <= 1'b0;
      r_timer          <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
    end else begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
      if (w_pop) begin
        r_jdo      <= w_head[DATA_W-1:0];
        r_cur_ch   <= w_head[DATA_W +: IR_W];
        r_act_flag <= w_head[DATA_W-1];
        r_timer    <= '0;
      end else if (r_state == ISSUE && !w_fire && r_timer != '1) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_fire) begin
        if (r_act_flag) r_take_action    <= w_onehot;
        else            r_take_no_action <= w_onehot;
      end
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow_err <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      if (w_overflow)     r_overflow_err <= 1'b1;
      else if (clear_err) r_overflow_err <= 1'b0;
      if (w_drop)         r_timeout_err  <= 1'b1;
      else if (clear_err) r_timeout_err  <= 1'b0;
    end
  end

  assign jdo            = r_jdo;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign fifo_count     = w_count;
  assign busy           = (r_state != IDLE) || (w_count != '0);
  assign overflow_err   = r_overflow_err;
  assign timeout_err    = r_timeout_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_debug_slave_cmd_dispatch.sv
// Bench for debug_slave_cmd_dispatch: table of single commands with
// cycle-exact checks, hand sequences for queueing corners, and a pulse
// scoreboard that matches every issued pulse against the expected order.
module tb_debug_slave_cmd_dispatch;
  import debug_slave_pkg::*;

  localparam int DW  = 38;
  localparam int IRW = 2;
  localparam int NCH = 4;
  localparam int TO  = 8;
  localparam int EW  = 2*NCH + DW;

  logic            clk = 1'b0;
  logic            reset;
  logic            upd_valid;
  logic [IRW-1:0]  upd_ir;
  logic [DW-1:0]   upd_data;
  logic [NCH-1:0]  ch_ready;
  logic            clear_err;
  logic [DW-1:0]   jdo;
  logic [NCH-1:0]  take_action;
  logic [NCH-1:0]  take_no_action;
  logic [2:0]      fifo_count;
  logic            busy;
  logic            overflow_err;
  logic            timeout_err;
  dispatch_state_t dbg_state;

  debug_slave_cmd_dispatch #(
    .DATA_W(DW), .IR_W(IRW), .FIFO_DEPTH(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ir(upd_ir),
    .upd_data(upd_data), .ch_ready(ch_ready), .clear_err(clear_err),
    .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
    .fifo_count(fifo_count), .busy(busy), .overflow_err(overflow_err),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [IRW-1:0] ir;
    logic [DW-1:0]  data;
    logic [NCH-1:0] ta;
    logic [NCH-1:0] tna;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [EW-1:0] exp_for(input logic [IRW-1:0] ir, input logic [DW-1:0] d);
    logic [NCH-1:0] oh;
    oh = NCH'(1) << ir;
    return d[DW-1] ? {oh, {NCH{1'b0}}, d} : {{NCH{1'b0}}, oh, d};
  endfunction

  // Advance to the next cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic [IRW-1:0] ir, input logic [DW-1:0] d, input bit expect_issue);
    upd_valid = 1'b1;
    upd_ir    = ir;
    upd_data  = d;
    if (expect_issue) exp_q.push_back(exp_for(ir, d));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || dbg_state != IDLE) && n < 100) begin
      step();
      n++;
    end
    chk({name, "_idle_budget"}, 64'(n < 100), 64'd1);
  endtask

  // Scoreboard monitor: every pulse must be one-hot, one cycle, and in order.
  logic [NCH-1:0] mon_p;
  logic [NCH-1:0] mon_prev = '0;
  logic [EW-1:0]  mon_e;
  always @(negedge clk) begin
    mon_p = take_action | take_no_action;
    if (mon_p != '0) begin
      chk("pulse_onehot", 64'((take_action != '0 && take_no_action != '0) || $countones(mon_p) != 1), 64'd0);
      chk("pulse_width", 64'(mon_prev), 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got ta=%0h tna=%0h expected none at %0t", take_action, take_no_action, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pulse_jdo", 64'({take_action, take_no_action}), 64'(mon_e[EW-1:DW]));
        chk("sb_jdo", 64'(jdo), 64'(mon_e[DW-1:0]));
      end
    end
    mon_prev = mon_p;
  end

  int pc[$];

  initial begin
    reset = 1'b1; upd_valid = 1'b0; upd_ir = '0; upd_data = '0;
    ch_ready = '0; clear_err = 1'b0;

    vecs[0] = '{ir: 2'd2, data: 38'h20_0000_00AB, ta: 4'b0100, tna: 4'b0000};
    vecs[1] = '{ir: 2'd0, data: 38'h00_0000_1234, ta: 4'b0000, tna: 4'b0001};
    vecs[2] = '{ir: 2'd1, data: 38'h3F_FFFF_FFFF, ta: 4'b0010, tna: 4'b0000};
    vecs[3] = '{ir: 2'd3, data: 38'h1F_FFFF_FFFF, ta: 4'b0000, tna: 4'b1000};
    for (int i = 4; i < 6; i++) begin
      vecs[i].ir   = IRW'($urandom_range(0, 3));
      vecs[i].data = {6'($urandom_range(0, 63)), 32'($urandom())};
      vecs[i].ta   = vecs[i].data[DW-1] ? (NCH'(1) << vecs[i].ir) : '0;
      vecs[i].tna  = vecs[i].data[DW-1] ? '0 : (NCH'(1) << vecs[i].ir);
    end

    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_jdo", 64'(jdo), 64'd0);
    chk("rst_pulses", 64'({take_action, take_no_action}), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_errs", 64'({overflow_err, timeout_err}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));

    // Table-driven single commands, cycle-exact
    ch_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step(); drive_upd(vecs[i].ir, vecs[i].data, 1'b1);           // cycle 0
      step(); upd_valid = 1'b0;                                   // cycle 1
      chk("vec_c1_count", 64'(fifo_count), 64'd1);
      step();                                                     // cycle 2
      chk("vec_c2_jdo", 64'(jdo), 64'(vecs[i].data));
      chk("vec_c2_state", 64'(dbg_state), 64'(ISSUE));
      chk("vec_c2_count", 64'(fifo_count), 64'd0);
      step();                                                     // cycle 3
      chk("vec_c3_ta", 64'(take_action), 64'(vecs[i].ta));
      chk("vec_c3_tna", 64'(take_no_action), 64'(vecs[i].tna));
      chk("vec_c3_busy", 64'(busy), 64'd0);
      step();                                                     // cycle 4
      chk("vec_c4_pulses", 64'({take_action, take_no_action}), 64'd0);
      chk("vec_c4_jdo_held", 64'(jdo), 64'(vecs[i].data));
    end

    // Back-pressure, ordering and overflow
    ch_ready = '0;
    for (int i = 0; i < 5; i++) begin
      step(); drive_upd(IRW'(i), {1'(i & 1), 37'(32'h100 + i)}, 1'b1);
    end
    step();                                                       // cycle 5
    chk("bp_count_full", 64'(fifo_count), 64'd4);
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_no_ovf_yet", 64'(overflow_err), 64'd0);
    drive_upd(2'd3, 38'h3A_5A5A_5A5A, 1'b0);                        // dropped
    step(); upd_valid = 1'b0;                                     // cycle 6
    chk("bp_ovf_set", 64'(overflow_err), 64'd1);
    chk("bp_count_hold", 64'(fifo_count), 64'd4);
    ch_ready = 4'b1111;
    pc.delete();
    for (int c = 7; c <= 18; c++) begin
      step();
      if ((take_action | take_no_action) != '0) pc.push_back(c);
    end
    chk("bp_pulse_count", 64'(pc.size()), 64'd5);
    if (pc.size() > 0) chk("bp_first_pulse", 64'(pc[0]), 64'd7);
    for (int i = 1; i < pc.size(); i++) chk("bp_pulse_gap", 64'(pc[i] - pc[i-1]), 64'd2);
    wait_idle("bp");
    step(); clear_err = 1'b1;
    step(); clear_err = 1'b0;
    chk("bp_ovf_cleared", 64'(overflow_err), 64'd0);

    // Full FIFO with push and pop on the same edge
    ch_ready = '0;
    for (int i = 0; i < 5; i++) begin
      step(); drive_upd(IRW'(3 - i), {1'(~i & 1), 37'(32'h200 + i)}, 1'b1);
    end
    step(); upd_valid = 1'b0;                                     // cycle 5
    chk("fp_count_full", 64'(fifo_count), 64'd4);
    ch_ready = 4'b1111;
    step();                                                       // cycle 6: pop edge
    chk("fp_state_idle", 64'(dbg_state), 64'(IDLE));
    ch_ready = '0;
    drive_upd(2'd1, 38'h20_0000_0777, 1'b1);
    step(); upd_valid = 1'b0;                                     // cycle 7
    chk("fp_count_same", 64'(fifo_count), 64'd4);
    chk("fp_no_ovf", 64'(overflow_err), 64'd0);
    ch_ready = 4'b1111;
    wait_idle("fp");

    // Timeout drop, then the next command proceeds
    ch_ready = '0;
    step(); drive_upd(2'd2, 38'h20_0000_0DEA, 1'b0);              // cycle 0 (will time out)
    step(); drive_upd(2'd1, 38'h00_0000_0B0B, 1'b1);              // cycle 1
    step(); upd_valid = 1'b0;                                     // cycle 2 = ISSUE entry
    chk("to_issue", 64'(dbg_state), 64'(ISSUE));
    repeat (7) step();                                            // cycle 9
    chk("to_not_yet", 64'(timeout_err), 64'd0);
    step();                                                       // cycle 10
    chk("to_set", 64'(timeout_err), 64'd1);
    chk("to_state_idle", 64'(dbg_state), 64'(IDLE));
    chk("to_no_pulse", 64'({take_action, take_no_action}), 64'd0);
    ch_ready = 4'b1111;
    step(); step();                                               // cycle 12
    chk("to_next_pulse", 64'(take_no_action), 64'b0010);
    wait_idle("to");
    step(); clear_err = 1'b1;
    step(); clear_err = 1'b0;
    chk("to_cleared", 64'(timeout_err), 64'd0);

    // Timeout coinciding with clear_err: set wins
    ch_ready = '0;
    step(); drive_upd(2'd0, 38'h20_0000_0C1C, 1'b0);              // cycle 0
    step(); upd_valid = 1'b0;                                     // cycle 1
    repeat (8) step();                                            // cycle 9
    chk("tc_pre", 64'(timeout_err), 64'd0);
    clear_err = 1'b1;
    step(); clear_err = 1'b0;                                     // cycle 10
    chk("tc_set_wins", 64'(timeout_err), 64'd1);
    wait_idle("tc");
    step(); clear_err = 1'b1;
    step(); clear_err = 1'b0;

    // Reset while in ISSUE with 3 entries queued
    ch_ready = '0;
    for (int i = 0; i < 4; i++) begin
      step(); drive_upd(IRW'(i), {1'b1, 37'(32'h300 + i)}, 1'b0);
    end
    step(); upd_valid = 1'b0;                                     // cycle 4
    chk("rm_count", 64'(fifo_count), 64'd3);
    chk("rm_state", 64'(dbg_state), 64'(ISSUE));
    reset = 1'b1; ch_ready = 4'b1111;
    step(); reset = 1'b0;                                         // cycle 5
    chk("rm_count0", 64'(fifo_count), 64'd0);
    chk("rm_jdo0", 64'(jdo), 64'd0);
    chk("rm_pulses0", 64'({take_action, take_no_action}), 64'd0);
    chk("rm_busy0", 64'(busy), 64'd0);
    step();
    chk("rm_after_pulses0", 64'({take_action, take_no_action}), 64'd0);
    repeat (3) step();

    chk("sb_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
